// File: rtl/issue_scoreboard.sv
// issue_scoreboard: holds decoded instructions until GPR/CSR operands are no longer pending; serializes ecall/mret and squashes after redirect
module issue_scoreboard #(
  parameter int CNT_W     = 2,
  parameter int FLUSH_CYC = 2,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_R_wen,
  input  logic              id_csr_use,
  input  logic [3:0]        id_csr_wen,
  input  logic              id_serial,
  input  logic              ex_ready,
  output logic              ex_valid,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              wb_R_wen,
  input  logic [3:0]        wb_csr_wen,
  input  logic              redirect,
  output logic              flush,
  output logic [PERF_W-1:0] stall_cnt,
  output logic              sb_err
);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0] fcnt, fcnt_nx;
  logic [31:0][CNT_W-1:0] pend, pend_nx;
  logic [2:0] csr_pend, csr_nx;
  logic [31:0] inc_v, dec_v;
  logic issue, hazard, any_pend, nx_zero, err_nx, csr_inc, csr_dec;
  assign issue    = id_valid & id_ready;
  assign ex_valid = issue;
  assign flush    = state == FLUSH;
  assign inc_v    = {32{issue & id_R_wen}} & (32'd1 << id_rd) & ~32'd1;
  assign dec_v    = {32{wb_valid & wb_R_wen}} & (32'd1 << wb_rd) & ~32'd1;
  assign csr_inc  = issue & |id_csr_wen;
  assign csr_dec  = wb_valid & |wb_csr_wen;
  // Hazards use the pre-edge counters: a retiring producer frees its consumer next cycle
  assign hazard = (id_use_rs1 && id_rs1 != 5'd0 && pend[id_rs1] != '0)
                | (id_use_rs2 && id_rs2 != 5'd0 && pend[id_rs2] != '0)
                | (id_csr_use && csr_pend != 3'd0)
                | (id_R_wen && id_rd != 5'd0 && pend[id_rd] == '1)
                | (csr_pend == 3'd7 && id_csr_wen != 4'd0);
  assign id_ready = rst_n && state == RUN && !redirect && ex_ready && !hazard
                  && !(id_serial && any_pend);
  always_comb begin
    pend_nx  = pend;
    err_nx   = sb_err;
    any_pend = csr_pend != 3'd0;
    nx_zero  = 1'b1;
    for (int i = 1; i < 32; i++) begin
      if (inc_v[i] && !dec_v[i]) pend_nx[i] = pend[i] + CNT_W'(1);
      else if (dec_v[i] && !inc_v[i]) begin
        if (pend[i] == '0) err_nx = 1'b1;
        else pend_nx[i] = pend[i] - CNT_W'(1);
      end
      any_pend = any_pend | (pend[i] != '0);
      nx_zero  = nx_zero & (pend_nx[i] == '0);
    end
    pend_nx[0] = '0;
    csr_nx = csr_pend;
    if (csr_inc && !csr_dec) csr_nx = csr_pend + 3'd1;
    else if (csr_dec && !csr_inc) begin
      if (csr_pend == 3'd0) err_nx = 1'b1;
      else csr_nx = csr_pend - 3'd1;
    end
    nx_zero = nx_zero & (csr_nx == 3'd0);
  end
  // DRAIN leaves as soon as the post-edge counters are empty so the serial op issues the cycle after the last retire
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    if (redirect) begin
      state_nx = FLUSH;
      fcnt_nx  = 4'(FLUSH_CYC - 1);
    end else if (state == RUN && id_valid && id_serial && any_pend) state_nx = DRAIN;
    else if (state == DRAIN && nx_zero) state_nx = RUN;
    else if (state == FLUSH) begin
      state_nx = fcnt == 4'd0 ? RUN : FLUSH;
      fcnt_nx  = fcnt == 4'd0 ? fcnt : fcnt - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fcnt      <= '0;
      pend      <= '0;
      csr_pend  <= '0;
      sb_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      fcnt     <= fcnt_nx;
      pend     <= pend_nx;
      csr_pend <= csr_nx;
      sb_err   <= err_nx;
      if (id_valid && !id_ready) stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end
endmodule
